// File: rtl/alu_share_pkg.sv
// alu_share_pkg: shared constants and types for the shared add/sub arbiter
// Provides the ADD op code, the FSM state type, default widths and the request bundle.
package alu_share_pkg;
    localparam int WIDTH_DEF = 16;
    localparam int OPW_DEF   = 4;
    localparam logic [OPW_DEF-1:0] OP_ADD = 4'd0;
    typedef enum logic {CFG, RUN} state_t;
    typedef struct packed {
        logic [OPW_DEF-1:0]   op;
        logic [WIDTH_DEF-1:0] a;
        logic [WIDTH_DEF-1:0] b;
    } req_t;
endpackage

// File: rtl/alu_addsub.sv
// alu_addsub: registered add/subtract stage with load enable
// Ports: clk, rst_n (async active-low), load (capture new result), op (0 = add,
// otherwise subtract), a, b (operands), result (registered, modulo 2^WIDTH).
module alu_addsub
    import alu_share_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OPW   = OPW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            result <= '0;
        else if (load)
            result <= (op == OPW'(OP_ADD)) ? a + b : a - b;
    end
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin arbiter sharing one add/sub datapath between two requesters
// Ports: clk, rst_n (async active-low); reqN_valid/ready/op/a/b for requesters 0 and 1;
// rsp_valid/ready/id/data result channel; cfg_done (config phase over);
// issue_count (saturating count of accepted operations).
module alu_share_arb
    import alu_share_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OPW   = OPW_DEF,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             cfg_done,
    output logic [CNTW-1:0]  issue_count
);
    state_t           state, state_next;
    logic [OPW-1:0]   op_reg;
    logic             prio;
    logic             grant;
    logic             can_accept;
    logic             accept;
    logic [OPW-1:0]   sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= CFG;
        else
            state <= state_next;
    end

    // prio names the requester that wins a tie; a lone valid requester always wins
    always_comb begin
        state_next = RUN;
        can_accept = (state == RUN) && (!rsp_valid || rsp_ready);
        grant      = (req0_valid && req1_valid) ? prio : req1_valid;
        req0_ready = can_accept && !grant;
        req1_ready = can_accept && grant;
        accept     = grant ? req1_valid && req1_ready : req0_valid && req0_ready;
        sel_op     = grant ? req1_op : req0_op;
        sel_a      = grant ? req1_a : req0_a;
        sel_b      = grant ? req1_b : req0_b;
    end

    assign cfg_done = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg      <= '0;
            prio        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            issue_count <= '0;
            sum_q       <= '0;
        end else begin
            if (state == CFG)
                op_reg <= OPW'(OP_ADD);
            else if (accept)
                op_reg <= sel_op;
            if (accept) begin
                rsp_id <= grant;
                prio   <= !grant;
                sum_q  <= sel_a + sel_b;
                if (issue_count != '1)
                    issue_count <= issue_count + CNTW'(1);
            end
            rsp_valid <= accept || (rsp_valid && !rsp_ready);
        end
    end

    alu_addsub #(.WIDTH(WIDTH), .OPW(OPW)) u_alu (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .op     (sel_op),
        .a      (sel_a),
        .b      (sel_b),
        .result (rsp_data)
    );

    // sum_q exists only to state the add invariant against the operands captured at accept
    a_add_sum: assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_valid && op_reg == OPW'(OP_ADD)) |-> (rsp_data == sum_q));
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: self-checking bench for alu_share_arb (vector table + scoreboard)
module tb_alu_share_arb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b1;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op = '0, req1_op = '0;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        rsp_valid, rsp_id, cfg_done;
    logic [15:0] rsp_data, issue_count;
    logic        s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id, s_cfg_done;
    logic [15:0] s_rsp_data;
    logic [2:0]  s_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_share_arb dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .cfg_done(cfg_done), .issue_count(issue_count)
    );

    // narrow-counter copy driven identically, to reach saturation in a few cycles
    alu_share_arb #(.CNTW(3)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id), .rsp_data(s_rsp_data),
        .cfg_done(s_cfg_done), .issue_count(s_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        return (op == 4'd0) ? a + b : a - b;
    endfunction

    typedef struct packed {
        logic        id;
        logic [15:0] data;
    } rsp_t;

    rsp_t q[$];
    logic m_run = 1'b0;
    logic m_prio = 1'b0;
    int   m_cnt = 0;
    logic m_can, m_g;

    assign m_can = m_run && (!rsp_valid || rsp_ready);
    assign m_g   = (req0_valid && req1_valid) ? m_prio : req1_valid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_run <= 1'b0;
        else        m_run <= 1'b1;
    end

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_prio <= 1'b0;
            m_cnt  <= 0;
        end else begin
            check("req0_ready", req0_ready, m_can && !m_g);
            check("req1_ready", req1_ready, m_can && m_g);
            check("cfg_done", cfg_done, m_run);
            check("rsp_valid", rsp_valid, q.size() != 0);
            check("issue_count", issue_count, m_cnt);
            check("sat_count", s_count, (m_cnt > 7) ? 7 : m_cnt);
            if (rsp_valid && rsp_ready && q.size() != 0) begin
                check("sb_rsp_id", rsp_id, q[0].id);
                check("sb_rsp_data", rsp_data, q[0].data);
                q.delete(0);
            end
            if (req0_valid && m_can && !m_g) begin
                q.push_back('{1'b0, ref_alu(req0_op, req0_a, req0_b)});
                m_prio <= 1'b1;
                m_cnt  <= m_cnt + 1;
            end else if (req1_valid && m_can && m_g) begin
                q.push_back('{1'b1, ref_alu(req1_op, req1_a, req1_b)});
                m_prio <= 1'b0;
                m_cnt  <= m_cnt + 1;
            end
        end
    end

    task automatic issue(input logic id, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic done;
        done = 1'b0;
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = id ? req1_ready : req0_ready;
        end
        check("issue_accepted", done, 1'b1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    typedef struct {
        logic        id;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic        prev;
        logic        gnt;
        logic [15:0] hold_d;
        logic        hold_id;
        vecs[0] = '{1'b1, 4'd5, 16'h0000, 16'h0001, 16'hFFFF};
        vecs[1] = '{1'b0, 4'd0, 16'hFFFF, 16'h0002, 16'h0001};
        vecs[2] = '{1'b1, 4'd0, 16'h1234, 16'h1111, 16'h2345};
        vecs[3] = '{1'b0, 4'd1, 16'h0010, 16'h0020, 16'hFFF0};
        vecs[4] = '{1'b1, 4'hF, 16'h8000, 16'h0001, 16'h7FFF};
        vecs[5] = '{1'b0, 4'd0, 16'h8000, 16'h8000, 16'h0000};
        vecs[6] = '{1'b1, 4'd2, 16'h0005, 16'h0005, 16'h0000};

        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_id", rsp_id, 1'b0);
        check("rst_rsp_data", rsp_data, 16'h0000);
        check("rst_cfg_done", cfg_done, 1'b0);
        check("rst_issue_count", issue_count, 16'h0000);

        // release with both requesters waiting: one CFG cycle, then req0 wins
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 16'h0003; req0_b = 16'h0004;
        req1_valid = 1'b1; req1_op = 4'd0; req1_a = 16'h0100; req1_b = 16'h0200;
        #1;
        check("cfg_req0_ready", req0_ready, 1'b0);
        check("cfg_req1_ready", req1_ready, 1'b0);
        @(posedge clk); #1;
        check("run_cfg_done", cfg_done, 1'b1);
        check("run_req0_ready", req0_ready, 1'b1);
        check("run_req1_ready", req1_ready, 1'b0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("first_rsp_valid", rsp_valid, 1'b1);
        check("first_rsp_id", rsp_id, 1'b0);
        check("first_rsp_data", rsp_data, 16'h0007);
        check("first_issue_count", issue_count, 16'h0001);

        foreach (vecs[i]) begin
            issue(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
            check("vec_rsp_valid", rsp_valid, 1'b1);
            check("vec_rsp_id", rsp_id, vecs[i].id);
            check("vec_rsp_data", rsp_data, vecs[i].exp);
        end

        // both valid every cycle: grants alternate and a result appears every cycle
        req0_valid = 1'b1; req0_op = 4'($urandom_range(0, 15)); req0_a = 16'($urandom); req0_b = 16'($urandom);
        req1_valid = 1'b1; req1_op = 4'($urandom_range(0, 15)); req1_a = 16'($urandom); req1_b = 16'($urandom);
        prev = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("one_ready", 32'(req0_ready) + 32'(req1_ready), 1);
            gnt = req1_ready;
            if (i > 0) begin
                check("alternate", gnt, !prev);
                check("stream_rsp_valid", rsp_valid, 1'b1);
                check("stream_rsp_id", rsp_id, prev);
            end
            prev = gnt;
            @(posedge clk); #1;
            if (gnt) begin
                req1_op = 4'($urandom_range(0, 15)); req1_a = 16'($urandom); req1_b = 16'($urandom);
            end else begin
                req0_op = 4'($urandom_range(0, 15)); req0_a = 16'($urandom); req0_b = 16'($urandom);
            end
        end

        // back-pressure: nothing accepted and the held result stays put
        rsp_ready = 1'b0;
        @(negedge clk);
        hold_d  = rsp_data;
        hold_id = rsp_id;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_req0_ready", req0_ready, 1'b0);
            check("bp_req1_ready", req1_ready, 1'b0);
            check("bp_rsp_valid", rsp_valid, 1'b1);
            check("bp_rsp_data", rsp_data, hold_d);
            check("bp_rsp_id", rsp_id, hold_id);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", req0_ready || req1_ready, 1'b1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("bp_new_rsp_valid", rsp_valid, 1'b1);
        @(posedge clk); #1;
        check("drain_rsp_valid", rsp_valid, 1'b0);

        // asynchronous reset while a response is pending
        rsp_ready = 1'b0;
        issue(1'b0, 4'd0, 16'h0010, 16'h0020);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", rsp_valid, 1'b0);
        check("mid_rst_issue_count", issue_count, 16'h0000);
        check("mid_rst_rsp_data", rsp_data, 16'h0000);
        check("mid_rst_cfg_done", cfg_done, 1'b0);
        check("mid_rst_sat_count", s_count, 3'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        req1_valid = 1'b1; req1_op = 4'd0; req1_a = 16'h0100; req1_b = 16'h0023;
        #1;
        check("recfg_req1_ready", req1_ready, 1'b0);
        check("recfg_cfg_done", cfg_done, 1'b0);
        @(posedge clk); #1;
        check("rerun_cfg_done", cfg_done, 1'b1);
        check("rerun_req1_ready", req1_ready, 1'b1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        check("rerun_rsp_data", rsp_data, 16'h0123);
        check("rerun_rsp_id", rsp_id, 1'b1);
        check("rerun_issue_count", issue_count, 16'h0001);

        // push the 3-bit counter copy past all-ones
        for (int i = 0; i < 8; i++)
            issue(1'(i), 4'd0, 16'(i), 16'h0001);
        check("sat_hold", s_count, 3'd7);
        check("sat_main_count", issue_count, 16'd9);
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "timeout");
    end
endmodule
